// File: rtl/nf_ahb_pkg.sv
// nf_ahb_pkg: shared AHB-Lite constants and types for the nanoFOX interconnect.
//   HTRANS_*    transfer type encodings
//   HRESP_*     response encodings
//   def_state_e default-slave FSM state
package nf_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DEF_IDLE = 2'd0,
        DEF_ERR1 = 2'd1,
        DEF_ERR2 = 2'd2
    } def_state_e;

endpackage

// File: rtl/nf_ahb_resp_mux_if.sv
// nf_ahb_resp_mux_if: bus bundle between decoder/slaves/master and the response mux.
//   hsel_dec, htrans              address-phase select and transfer type
//   hrdata_s, hresp_s, hreadyout_s per-slave data-phase responses
//   hrdata, hresp, hready          combined response to the master
// Modport slave is taken by the mux; modport master by whatever drives it.
interface nf_ahb_resp_mux_if #(
    parameter int SLAVE_C = 4
);
    logic [SLAVE_C-1:0]       hsel_dec;
    logic [1:0]               htrans;
    logic [SLAVE_C-1:0][31:0] hrdata_s;
    logic [SLAVE_C-1:0]       hresp_s;
    logic [SLAVE_C-1:0]       hreadyout_s;
    logic [31:0]              hrdata;
    logic                     hresp;
    logic                     hready;

    modport slave (
        input  hsel_dec, htrans, hrdata_s, hresp_s, hreadyout_s,
        output hrdata, hresp, hready
    );

    modport master (
        output hsel_dec, htrans, hrdata_s, hresp_s, hreadyout_s,
        input  hrdata, hresp, hready
    );
endinterface

// File: rtl/nf_ahb_resp_mux_def_slave.sv
// nf_ahb_def_slave: default slave giving the two-cycle AHB ERROR response to
// active transfers that hit no mapped slave.
//   clk, resetn  clock and synchronous active-low reset
//   hready       combined bus hready (address phase is sampled when high)
//   htrans       master transfer type
//   hsel_none    no decoder hit for the current address phase
//   def_hready   default-slave hready (low only in ERR1)
//   def_hresp    default-slave hresp (ERROR in ERR1 and ERR2)
module nf_ahb_def_slave
    import nf_ahb_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       hready,
    input  logic [1:0] htrans,
    input  logic       hsel_none,
    output logic       def_hready,
    output logic       def_hresp
);

    def_state_e state_q, state_d;
    logic       err_req;
    logic       unused_htrans;

    assign unused_htrans = htrans[0];

    // Unmapped active transfer accepted this cycle.
    assign err_req = hready && htrans[1] && hsel_none;

    always_comb begin
        state_d = state_q;
        case (state_q)
            DEF_IDLE: if (err_req) state_d = DEF_ERR1;
            DEF_ERR1: state_d = DEF_ERR2;
            DEF_ERR2: state_d = err_req ? DEF_ERR1 : DEF_IDLE;
            default:  state_d = DEF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= DEF_IDLE;
        else         state_q <= state_d;
    end

    assign def_hready = (state_q != DEF_ERR1);
    assign def_hresp  = (state_q == DEF_ERR1 || state_q == DEF_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/nf_ahb_resp_mux.sv
// nf_ahb_resp_mux: AHB-Lite response path. Registers the decoder select at
// the address phase and muxes the selected slave's response back in the data
// phase; unmapped transfers are answered by the built-in default slave.
//   clk, resetn  clock and synchronous active-low reset
//   bus          nf_ahb_resp_mux_if.slave (select, htrans, slave responses in;
//                hrdata/hresp/hready out)
module nf_ahb_resp_mux
    import nf_ahb_pkg::*;
#(
    parameter int slave_c = 4
) (
    input  logic               clk,
    input  logic               resetn,
    nf_ahb_resp_mux_if.slave   bus
);

    logic [slave_c-1:0] sel_dp_q, sel_dp_d;
    logic [slave_c-1:0] hsel_pri;
    logic               hsel_none;
    logic               def_hready, def_hresp;
    logic [31:0]        hrdata_w;
    logic               hresp_w, hready_w;

    // Isolate lowest set bit: overlapping decoder hits go to the lowest index.
    assign hsel_pri  = bus.hsel_dec & (~bus.hsel_dec + slave_c'(1));
    assign hsel_none = (bus.hsel_dec == '0);

    always_comb begin
        sel_dp_d = sel_dp_q;
        if (hready_w) sel_dp_d = bus.htrans[1] ? hsel_pri : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) sel_dp_q <= '0;
        else         sel_dp_q <= sel_dp_d;
    end

    nf_ahb_def_slave u_def_slave (
        .clk        (clk),
        .resetn     (resetn),
        .hready     (hready_w),
        .htrans     (bus.htrans),
        .hsel_none  (hsel_none),
        .def_hready (def_hready),
        .def_hresp  (def_hresp)
    );

    // AND-OR mux on the one-hot select so unselected slave values are masked.
    always_comb begin
        hrdata_w = '0;
        hresp_w  = 1'b0;
        hready_w = 1'b0;
        for (int i = 0; i < slave_c; i++) begin
            hrdata_w = hrdata_w | ({32{sel_dp_q[i]}} & bus.hrdata_s[i]);
            hresp_w  = hresp_w  | (sel_dp_q[i] & bus.hresp_s[i]);
            hready_w = hready_w | (sel_dp_q[i] & bus.hreadyout_s[i]);
        end
        if (sel_dp_q == '0) begin
            hrdata_w = '0;
            hresp_w  = def_hresp;
            hready_w = def_hready;
        end
    end

    assign bus.hrdata = hrdata_w;
    assign bus.hresp  = hresp_w;
    assign bus.hready = hready_w;

endmodule

// File: tb/tb_nf_ahb_resp_mux.sv
module tb_nf_ahb_resp_mux;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic resetn;
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model: which slave owns the current data phase (-1: none)
    // and how far into an ERROR response the default slave is (0/1/2).
    int   m_slave = -1;
    int   m_err   = 0;

    nf_ahb_resp_mux_if #(.SLAVE_C(NS)) bus ();

    nf_ahb_resp_mux #(.slave_c(NS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_expect(output logic [31:0] rd, output logic rs, output logic ry);
        if (m_slave >= 0) begin
            rd = bus.hrdata_s[m_slave];
            rs = bus.hresp_s[m_slave];
            ry = bus.hreadyout_s[m_slave];
        end else begin
            rd = 32'h0;
            rs = (m_err != 0);
            ry = (m_err != 1);
        end
    endtask

    task automatic model_update(input logic ry);
        int lo;
        if (!resetn) begin
            m_slave = -1;
            m_err   = 0;
        end else if (ry) begin
            // Data phase completes; the presented address phase is accepted.
            m_slave = -1;
            m_err   = 0;
            if (bus.htrans[1]) begin
                lo = -1;
                for (int i = NS - 1; i >= 0; i--)
                    if (bus.hsel_dec[i]) lo = i;
                if (lo < 0) m_err = 1;
                else        m_slave = lo;
            end
        end else if (m_err == 1) begin
            m_err = 2;
        end
    endtask

    task automatic step(input logic rst_n, input logic [1:0] tr, input logic [NS-1:0] sel,
                        input logic [NS-1:0] rdy, input logic [NS-1:0] rsp, input logic [31:0] d1);
        logic [31:0] er;
        logic        ep, ey;
        resetn          = rst_n;
        bus.htrans      = tr;
        bus.hsel_dec    = sel;
        bus.hreadyout_s = rdy;
        bus.hresp_s     = rsp;
        for (int i = 0; i < NS; i++) bus.hrdata_s[i] = $urandom;
        bus.hrdata_s[1] = d1;
        #1;
        model_expect(er, ep, ey);
        chk("hrdata", bus.hrdata, er);
        chk("hresp", {31'b0, bus.hresp}, {31'b0, ep});
        chk("hready", {31'b0, bus.hready}, {31'b0, ey});
        @(posedge clk);
        model_update(ey);
        #1;
    endtask

    initial begin
        logic [NS-1:0] s, r;
        resetn = 1'b0;
        bus.htrans = 2'b00; bus.hsel_dec = '0; bus.hreadyout_s = '1;
        bus.hresp_s = '0; bus.hrdata_s = '0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state and slave1 read
        step(1, 2'b10, 4'b0010, 4'hF, 4'h0, $urandom);
        step(1, 2'b00, 4'b0000, 4'hF, 4'h0, 32'hDEADBEEF);
        // Slave2 with 3 wait states, new request during stall ignored
        step(1, 2'b10, 4'b0100, 4'hF, 4'h0, $urandom);
        repeat (3) step(1, 2'b10, 4'b0001, 4'b1011, 4'h0, $urandom);
        step(1, 2'b00, 4'b0000, 4'hF, 4'h0, $urandom);
        // Unmapped: ERR1, ERR2, then IDLE; then back-to-back unmapped
        step(1, 2'b10, 4'b0000, 4'hF, 4'h0, $urandom);
        repeat (3) step(1, 2'b00, 4'b0000, 4'hF, 4'h0, $urandom);
        step(1, 2'b11, 4'b0000, 4'hF, 4'h0, $urandom);
        step(1, 2'b00, 4'b0000, 4'hF, 4'h0, $urandom);
        step(1, 2'b10, 4'b0000, 4'hF, 4'h0, $urandom);
        repeat (3) step(1, 2'b00, 4'b0000, 4'hF, 4'h0, $urandom);
        // Overlapping hits, IDLE with a select
        step(1, 2'b10, 4'b0110, 4'hF, 4'h0, $urandom);
        step(1, 2'b00, 4'b0001, 4'hF, 4'hF, $urandom);
        step(1, 2'b01, 4'b0001, 4'hF, 4'hF, $urandom);
        // Reset in ERR1 and during a slave2 wait state
        step(1, 2'b10, 4'b0000, 4'hF, 4'h0, $urandom);
        step(0, 2'b00, 4'b0000, 4'hF, 4'h0, $urandom);
        step(1, 2'b00, 4'b0000, 4'hF, 4'h0, $urandom);
        step(1, 2'b10, 4'b0100, 4'hF, 4'h0, $urandom);
        step(0, 2'b00, 4'b0000, 4'b1011, 4'h0, $urandom);
        step(1, 2'b00, 4'b0000, 4'b1011, 4'h0, $urandom);
        // Slave3 two-cycle ERROR passed through
        step(1, 2'b10, 4'b1000, 4'hF, 4'h0, $urandom);
        step(1, 2'b10, 4'b1000, 4'b0111, 4'b1000, $urandom);
        step(1, 2'b00, 4'b0000, 4'hF, 4'b1000, $urandom);
        step(1, 2'b00, 4'b0000, 4'hF, 4'h0, $urandom);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(3))
                0: s = '0;
                1: s = 4'(1 << $urandom_range(NS - 1));
                default: s = 4'($urandom);
            endcase
            for (int i = 0; i < NS; i++) r[i] = ($urandom_range(3) != 0);
            step(($urandom_range(40) != 0), 2'($urandom), s, r, 4'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
